ps2_key_decoder: RTL

//  PS/2 keyboard front end for the synth IO controller. Receives device-to-host PS/2 frames and

---
 rtl/ps2_keymap_pkg.sv | 68 ++++++
 rtl/ps2_rx.sv | 119 +++++++++++
 rtl/ps2_key_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/ps2_keymap_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
//   - scan-code constants for every mapped key (set 2 make codes)
//   - break (F0) and extended (E0) prefix bytes
//   - key_to_note(): maps a scan code to {hit, note index 0..11}
//   - rx_state_t: receiver frame FSM states
package ps2_keymap_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Note keys, C..B
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_J = 8'h3B;

  // Command keys
  localparam logic [7:0] SC_OCT_DN  = 8'h1A; // Z
  localparam logic [7:0] SC_OCT_UP  = 8'h22; // X
  localparam logic [7:0] SC_AMP_DN  = 8'h21; // C
  localparam logic [7:0] SC_AMP_UP  = 8'h2A; // V
  localparam logic [7:0] SC_ADSR_DN = 8'h31; // N
  localparam logic [7:0] SC_ADSR_UP = 8'h3A; // M

  // ADSR parameter select keys 1..4
  localparam logic [7:0] SC_SEL_1 = 8'h16;
  localparam logic [7:0] SC_SEL_2 = 8'h1E;
  localparam logic [7:0] SC_SEL_3 = 8'h26;
  localparam logic [7:0] SC_SEL_4 = 8'h25;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Returns {hit, idx}; idx is 0 when hit is 0.
  function automatic logic [4:0] key_to_note(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      SC_A:    r = {1'b1, 4'd0};
      SC_W:    r = {1'b1, 4'd1};
      SC_S:    r = {1'b1, 4'd2};
      SC_E:    r = {1'b1, 4'd3};
      SC_D:    r = {1'b1, 4'd4};
      SC_F:    r = {1'b1, 4'd5};
      SC_T:    r = {1'b1, 4'd6};
      SC_G:    r = {1'b1, 4'd7};
      SC_Y:    r = {1'b1, 4'd8};
      SC_H:    r = {1'b1, 4'd9};
      SC_U:    r = {1'b1, 4'd10};
      SC_J:    r = {1'b1, 4'd11};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
//   clk, reset     : system clock, asynchronous active-low reset
//   ps2_clk/ps2_dat: raw PS/2 pins (asynchronous to clk)
//   scan_valid     : 1-cycle strobe, good frame received
//   scan_code      : last good byte, holds between strobes
//   frame_err      : 1-cycle strobe on bad start/parity/stop or mid-frame timeout
module ps2_rx
  import ps2_keymap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             clk_sync_p0, clk_sync_p1;
  logic             dat_sync_p0, dat_sync_p1;
  logic             clk_prev_p2;
  logic             fall_p2;
  logic             dat_p2;
  rx_state_t        state;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             parity_ok;
  logic [CNT_W-1:0] idle_cnt;

  // Stage p0/p1: two-flop synchronizers, loaded high so reset looks like an idle bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= ps2_clk;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= ps2_dat;
      dat_sync_p1 <= dat_sync_p0;
    end
  end

  // Stage p2: falling-edge detect; data captured alongside so FSM sees a matched pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_p2 <= 1'b1;
      fall_p2     <= 1'b0;
      dat_p2      <= 1'b1;
    end else begin
      clk_prev_p2 <= clk_sync_p1;
      fall_p2     <= clk_prev_p2 & ~clk_sync_p1;
      dat_p2      <= dat_sync_p1;
    end
  end

  // Stage p3: frame FSM, one bit per sample event, plus mid-frame timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      shift      <= 8'd0;
      bit_cnt    <= 3'd0;
      parity_ok  <= 1'b0;
      idle_cnt   <= '0;
      scan_valid <= 1'b0;
      scan_code  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE) begin
        idle_cnt <= '0;
        // A high data bit on an idle bus is line noise, not a framing error
        if (fall_p2 && !dat_p2) begin
          state   <= RX_DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall_p2) begin
        idle_cnt <= '0;
        case (state)
          RX_DATA: begin
            shift   <= {dat_p2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            // Odd parity: data bits plus parity bit must hold an odd number of ones
            parity_ok <= ^{shift, dat_p2};
            state     <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (parity_ok && dat_p2) begin
              scan_valid <= 1'b1;
              scan_code  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end else if (idle_cnt == CNT_LAST) begin
        // Keyboard stopped clocking mid-frame: abandon the partial byte
        frame_err <= 1'b1;
        state     <= RX_IDLE;
        idle_cnt  <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the synth IO controller: receives PS/2 frames
// and turns make/break scan codes into held-note state, +/- command strobes
// and the ADSR parameter selector.
//   clk, reset            : system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat      : raw PS/2 pins
//   note_in, note         : held-note flag and index (0..11, C..B) of last note make
//   octave_/amp_/ADSR_plus_plus/minus_minus : 1-cycle adjust strobes
//   ADSR_selector         : 0 attack, 1 decay, 2 sustain, 3 release
//   scan_valid, scan_code : raw good-frame strobe and last good byte
//   frame_err             : 1-cycle strobe on a bad or timed-out frame
module ps2_key_decoder
  import ps2_keymap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       note_in,
  output logic [3:0] note,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic       amp_plus_plus,
  output logic       amp_minus_minus,
  output logic [1:0] ADSR_selector,
  output logic       ADSR_plus_plus,
  output logic       ADSR_minus_minus,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic       brk;
  logic       ext;
  logic [7:0] held_code;
  logic [4:0] note_hit;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  assign note_hit = key_to_note(scan_code);

  // Stage p4: decode one byte per scan_valid into registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk                <= 1'b0;
      ext                <= 1'b0;
      held_code          <= 8'd0;
      note_in            <= 1'b0;
      note               <= 4'd0;
      octave_plus_plus   <= 1'b0;
      octave_minus_minus <= 1'b0;
      amp_plus_plus      <= 1'b0;
      amp_minus_minus    <= 1'b0;
      ADSR_selector      <= 2'd0;
      ADSR_plus_plus     <= 1'b0;
      ADSR_minus_minus   <= 1'b0;
    end else begin
      octave_plus_plus   <= 1'b0;
      octave_minus_minus <= 1'b0;
      amp_plus_plus      <= 1'b0;
      amp_minus_minus    <= 1'b0;
      ADSR_plus_plus     <= 1'b0;
      ADSR_minus_minus   <= 1'b0;

      if (frame_err) begin
        // A lost byte may have been the key following a prefix; drop the prefix too
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (scan_valid) begin
        if (scan_code == SC_BREAK) begin
          brk <= 1'b1;
        end else if (scan_code == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (ext) begin
            // Extended keys (arrows, keypad etc.) are not mapped
          end else if (brk) begin
            // Only releasing the currently held note ends it
            if (note_in && scan_code == held_code) note_in <= 1'b0;
          end else if (note_hit[4]) begin
            note_in   <= 1'b1;
            note      <= note_hit[3:0];
            held_code <= scan_code;
          end else begin
            case (scan_code)
              SC_OCT_UP:  octave_plus_plus   <= 1'b1;
              SC_OCT_DN:  octave_minus_minus <= 1'b1;
              SC_AMP_UP:  amp_plus_plus      <= 1'b1;
              SC_AMP_DN:  amp_minus_minus    <= 1'b1;
              SC_ADSR_UP: ADSR_plus_plus     <= 1'b1;
              SC_ADSR_DN: ADSR_minus_minus   <= 1'b1;
              SC_SEL_1:   ADSR_selector      <= 2'd0;
              SC_SEL_2:   ADSR_selector      <= 2'd1;
              SC_SEL_3:   ADSR_selector      <= 2'd2;
              SC_SEL_4:   ADSR_selector      <= 2'd3;
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
